program_frame_receiver: RTL and testbench
=========================================

Name: program_frame_receiver

Overview:
- Front-end stage directly upstream of the program loader.
- Accepts a framed byte stream (host link, valid/ready) and unpacks it into one-cycle address/data write strobes that drive the loader's prog_addr / prog_data_in / prog_write_enable inputs.
- Validates frame length and an 8-bit checksum.
- Raises start_execution only after a good frame, so the CPU never runs a partially or corruptly loaded image.

Parameters:
- ADDR_WIDTH, 5, program memory address width (32 words).
- DATA_WIDTH, 8, byte/word width.
- MAX_WORDS, 32, maximum legal payload count per frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rx_data  input  DATA_WIDTH  incoming stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  receiver can accept; a byte transfers on a clock edge with rx_valid && rx_ready.
- prog_addr  output  ADDR_WIDTH  write address to loader.
- prog_data  output  DATA_WIDTH  write data to loader.
- prog_write_enable  output  1  one cycle per payload byte.
- frame_done  output  1  one-cycle pulse, good frame.
- frame_error  output  1  one-cycle pulse, bad count or checksum.
- busy  output  1  high from accepted SYNC until frame ends.
- start_execution  output  1  level; go signal for CPU.

Behaviour:
- Reset (async): state=IDLE; rx_ready=0, prog_addr=0, prog_data=0, prog_write_enable=0, frame_done=0, frame_error=0, busy=0, start_execution=0. rx_ready rises the first cycle after reset deasserts.
- Frame format: SYNC, COUNT N, START address, N payload bytes, CHECKSUM.
  - Checksum is valid when (N + START + sum(payload) + CHECKSUM) mod 256 == 0.
- State machine: IDLE -> COUNT -> ADDR -> PAYLOAD -> CHECK -> DONE | ERROR -> IDLE.
  - IDLE: non-SYNC bytes are consumed and discarded. An accepted SYNC moves to COUNT, sets busy=1 and clears start_execution.
  - COUNT: N==0 or N>MAX_WORDS -> ERROR. Otherwise latch N into a remaining counter and init the running sum to N.
  - ADDR: latch START[ADDR_WIDTH-1:0] as the write pointer; add the full 8-bit START to the sum.
  - PAYLOAD: each accepted byte is registered into prog_data/prog_addr with prog_write_enable=1 in the following cycle.
    - Pointer increments modulo 2^ADDR_WIDTH (31 wraps to 0).
    - Byte is added to the sum; counter decrements.
    - Last byte -> CHECK.
    - Back-to-back bytes give contiguous write_enable cycles; gaps in rx_valid give write_enable=0 cycles, with prog_addr/prog_data holding their last values.
  - CHECK: accepted byte completes the sum. Zero -> DONE, else -> ERROR.
  - DONE (1 cycle): frame_done=1, start_execution set to 1 (held until next accepted SYNC or reset), busy=0, rx_ready=0.
  - ERROR (1 cycle): frame_error=1, busy=0, rx_ready=0, start_execution stays 0.
- rx_ready=1 in IDLE, COUNT, ADDR, PAYLOAD, CHECK; 0 in DONE and ERROR.
- Latency: payload byte accepted at edge k -> write_enable high for the cycle after edge k. frame_done/frame_error go high the cycle after the CHECK (or COUNT) byte is accepted.
- Payload writes are not rolled back on checksum failure; the failure is signalled only through frame_error and start_execution staying low.
- SYNC value received inside a frame is treated as ordinary data; no resynchronisation.
- Reset mid-frame: immediate return to IDLE with all outputs cleared; memory already written is untouched.
- Sum arithmetic is 8-bit wrap-around; the counter is wide enough for MAX_WORDS.

Test Plan:
- Good frame A5 03 00 11 22 33 97, rx_valid constant -> writes (0,11),(1,22),(2,33) on 3 consecutive cycles; frame_done pulse; start_execution=1; frame_error never set.
- Wrap frame A5 02 1F AA BB 7A -> writes (31,AA) then (0,BB); frame_done pulse.
- Bad count A5 00 and A5 21 -> frame_error pulse the cycle after the count byte; zero writes; rx_ready low one cycle; next A5 accepted.
- Bad checksum A5 01 05 44 00 -> one write (5,44), frame_error pulse, start_execution stays 0. A following good frame sets it to 1.
- Garbage 00 FF 5A before SYNC, plus random rx_valid gaps in payload -> garbage ignored. Writes occur only on cycles after accepted bytes, with correct addresses and data.
- Reset asserted after 2 of 3 payload bytes -> all outputs 0 immediately, busy=0. A new full frame afterwards completes with frame_done.

Source files
------------

// File: rtl/program_frame_receiver.sv
// program_frame_receiver: unpacks SYNC/COUNT/START/payload/CHECKSUM frames into loader write strobes
module program_frame_receiver #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS = 32,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_write_enable,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  busy,
  output logic                  start_execution
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {IDLE, COUNT, ADDR, PAYLOAD, CHECK, DONE, ERROR} state_t;
  state_t state, next;
  logic live, accept;
  logic [CW-1:0] remaining;
  logic [DATA_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] ptr;
  // live keeps rx_ready low while reset is held, even though state already reads IDLE
  assign rx_ready = live && state != DONE && state != ERROR;
  assign accept = rx_valid && rx_ready;
  assign busy = state inside {COUNT, ADDR, PAYLOAD, CHECK};
  assign frame_done = state == DONE;
  assign frame_error = state == ERROR;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept && rx_data == SYNC_BYTE) next = COUNT;
      COUNT:   if (accept) next = (rx_data == '0 || rx_data > DATA_WIDTH'(MAX_WORDS)) ? ERROR : ADDR;
      ADDR:    if (accept) next = PAYLOAD;
      PAYLOAD: if (accept && remaining == CW'(1)) next = CHECK;
      CHECK:   if (accept) next = (DATA_WIDTH'(sum + rx_data) == '0) ? DONE : ERROR;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      live <= 1'b0;
      remaining <= '0;
      sum <= '0;
      ptr <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_write_enable <= 1'b0;
      start_execution <= 1'b0;
    end else begin
      live <= 1'b1;
      prog_write_enable <= 1'b0;
      if (accept)
        case (state)
          IDLE: if (rx_data == SYNC_BYTE) start_execution <= 1'b0;
          COUNT: begin
            remaining <= rx_data[CW-1:0];
            sum <= rx_data;
          end
          ADDR: begin
            ptr <= rx_data[ADDR_WIDTH-1:0];
            sum <= sum + rx_data;
          end
          PAYLOAD: begin
            prog_addr <= ptr;
            prog_data <= rx_data;
            prog_write_enable <= 1'b1;
            ptr <= ptr + 1'b1;
            sum <= sum + rx_data;
            remaining <= remaining - 1'b1;
          end
          default: ;
        endcase
      if (next == DONE) start_execution <= 1'b1;
    end
endmodule

// File: tb/tb_program_frame_receiver.sv
// tb_program_frame_receiver: random and directed frames checked through a timestamped scoreboard
module tb_program_frame_receiver;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic rx_ready, prog_write_enable, frame_done, frame_error, busy, start_execution;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;

  program_frame_receiver dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_write_enable(prog_write_enable),
    .frame_done(frame_done), .frame_error(frame_error), .busy(busy), .start_execution(start_execution)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  typedef struct {logic [4:0] a; logic [7:0] d; time t;} wr_t;
  typedef struct {bit ok; time t;} res_t;
  wr_t wq[$];
  res_t rq[$];
  wr_t w;
  res_t r;
  logic [7:0] pl[32];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_prog_addr"}, 32'(prog_addr), 0);
    chk({tag, "_prog_data"}, 32'(prog_data), 0);
    chk({tag, "_write_enable"}, 32'(prog_write_enable), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_error"}, 32'(frame_error), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_start_execution"}, 32'(start_execution), 0);
  endtask

  // Monitor: every write and every frame outcome must match the head of its queue at its due time.
  always @(negedge clock) if (!reset) begin
    while (wq.size() > 0 && wq[0].t < $time) begin
      w = wq.pop_front();
      checks++; errors++;
      $display("FAIL missing_write exp addr=%0d data=%h due %0t", w.a, w.d, w.t);
    end
    while (rq.size() > 0 && rq[0].t < $time) begin
      r = rq.pop_front();
      checks++; errors++;
      $display("FAIL missing_frame_result exp ok=%0d due %0t", r.ok, r.t);
    end
    if (prog_write_enable) begin
      if (wq.size() == 0 || wq[0].t != $time) begin
        checks++; errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h at %0t", prog_addr, prog_data, $time);
      end else begin
        w = wq.pop_front();
        chk("write_addr", 32'(prog_addr), 32'(w.a));
        chk("write_data", 32'(prog_data), 32'(w.d));
      end
    end
    if (frame_done || frame_error) begin
      if (rq.size() == 0 || rq[0].t != $time) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_result got done=%0d error=%0d at %0t", frame_done, frame_error, $time);
      end else begin
        r = rq.pop_front();
        chk("frame_done", 32'(frame_done), 32'(r.ok));
        chk("frame_error", 32'(frame_error), 32'(!r.ok));
        chk("start_execution_at_end", 32'(start_execution), 32'(r.ok));
        chk("busy_at_end", 32'(busy), 0);
        chk("rx_ready_at_end", 32'(rx_ready), 0);
      end
    end
  end

  // Present one byte (after optional idle gap) and return the time of the edge that took it.
  task automatic send(input logic [7:0] b, input int gap, output time t);
    int tries;
    bit rdy;
    repeat (gap) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data = b;
    tries = 0;
    forever begin
      rdy = rx_ready;
      @(posedge clock);
      if (rdy) break;
      tries++;
      if (tries > 20) begin
        checks++; errors++;
        $display("FAIL accept_timeout byte=%h", b);
        break;
      end
      @(negedge clock);
    end
    t = $time;
  endtask

  task automatic idle();
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  // Reference: expected writes and outcome derived from the frame contents alone.
  task automatic send_frame(input logic [7:0] n, input logic [7:0] s, input logic [7:0] ck, input int maxgap);
    time t;
    int sum;
    send(8'hA5, $urandom_range(maxgap, 0), t);
    send(n, $urandom_range(maxgap, 0), t);
    if (n == 0 || n > 32) begin
      rq.push_back('{1'b0, t + 5});
      idle();
      return;
    end
    send(s, $urandom_range(maxgap, 0), t);
    sum = int'(n) + int'(s);
    for (int i = 0; i < int'(n); i++) begin
      send(pl[i], $urandom_range(maxgap, 0), t);
      wq.push_back('{5'((int'(s) + i) % 32), pl[i], t + 5});
      sum += int'(pl[i]);
    end
    send(ck, $urandom_range(maxgap, 0), t);
    rq.push_back('{((sum + int'(ck)) % 256) == 0, t + 5});
    idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    time t;
    logic [7:0] n, s, ck;
    int sum;
    #1;
    chk_idle_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    #1 chk("rx_ready_before_first_edge", 32'(rx_ready), 0);
    @(posedge clock);
    #1 chk("rx_ready_after_reset", 32'(rx_ready), 1);

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(8'h03, 8'h00, 8'h97, 0);
    repeat (2) @(negedge clock);
    chk("start_execution_held", 32'(start_execution), 1);

    pl[0] = 8'hAA; pl[1] = 8'hBB;
    send_frame(8'h02, 8'h1F, 8'h7A, 0);

    send_frame(8'h00, 8'h00, 8'h00, 0);
    send_frame(8'h21, 8'h00, 8'h00, 0);

    pl[0] = 8'h44;
    send_frame(8'h01, 8'h05, 8'h00, 0);
    repeat (2) @(negedge clock);
    chk("start_execution_after_bad_ck", 32'(start_execution), 0);

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send(8'h00, 0, t);
    send(8'hFF, 1, t);
    send(8'h5A, 0, t);
    send_frame(8'h03, 8'h00, 8'h97, 3);

    pl[0] = 8'hA5; pl[1] = 8'h01;
    send_frame(8'h02, 8'h10, 8'h48, 2);

    // Partial frame cut short by reset after two payload bytes.
    send(8'hA5, 0, t);
    send(8'h03, 0, t);
    send(8'h00, 0, t);
    send(8'h11, 0, t);
    wq.push_back('{5'd0, 8'h11, t + 5});
    send(8'h22, 0, t);
    wq.push_back('{5'd1, 8'h22, t + 5});
    @(negedge clock);
    rx_valid = 1'b0;
    #1 reset = 1'b1;
    #1 chk_idle_outputs("mid_frame_reset");
    chk("queues_empty_at_reset", 32'(wq.size() + rq.size()), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 chk("rx_ready_after_reset2", 32'(rx_ready), 1);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(8'h03, 8'h00, 8'h97, 1);

    for (int f = 0; f < 25; f++) begin
      for (int g = $urandom_range(3, 0); g > 0; g--) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        send(gb, $urandom_range(1, 0), t);
      end
      if ($urandom_range(7, 0) == 0) n = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 33));
      else n = 8'($urandom_range(32, 1));
      s = 8'($urandom);
      sum = int'(n) + int'(s);
      for (int i = 0; i < 32; i++) begin
        pl[i] = 8'($urandom);
        if (i < int'(n)) sum += int'(pl[i]);
      end
      ck = 8'((256 - (sum % 256)) % 256);
      if ($urandom_range(3, 0) == 0) ck = ck + 8'($urandom_range(255, 1));
      send_frame(n, s, ck, 2);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 32'(wq.size() + rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
